// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command FIFO plus a three-state issue FSM that drives a
// combinational ALU, holds its inputs for SETTLE_CYCLES, then captures the
// result behind a valid/ready handshake.
// Optional feature macro: ALU_ISSUE_DZ_CHECK_EN (short-circuits divide/modulo
// by zero without driving the ALU and flags it on res_dz).
module alu_issue_ctrl #(
    parameter int DATA_WIDTH    = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_sel,
    input  logic [DATA_WIDTH-1:0]         cmd_in0,
    input  logic [DATA_WIDTH-1:0]         cmd_in1,
    output logic [2:0]                    alu_sel,
    output logic [DATA_WIDTH-1:0]         alu_in0,
    output logic [DATA_WIDTH-1:0]         alu_in1,
    input  logic signed [2*DATA_WIDTH:0]  alu_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic signed [2*DATA_WIDTH:0]  res_data,
    output logic [2:0]                    res_sel,
    output logic                          res_dz,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int RES_W = 2 * DATA_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef struct packed {
        logic [2:0]            sel;
        logic [DATA_WIDTH-1:0] in0;
        logic [DATA_WIDTH-1:0] in1;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    cmd_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop, empty;
    cmd_t             head, wr_cmd;
    logic             head_dz;

    // Issue FSM and output registers
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              alu_sel_q, alu_sel_d;
    logic [DATA_WIDTH-1:0]   alu_in0_q, alu_in0_d;
    logic [DATA_WIDTH-1:0]   alu_in1_q, alu_in1_d;
    logic                    res_valid_q, res_valid_d;
    logic signed [RES_W-1:0] res_data_q, res_data_d;
    logic [2:0]              res_sel_q, res_sel_d;
    logic                    res_dz_q, res_dz_d;

    assign empty     = (count_q == '0);
    assign cmd_ready = (count_q != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign wr_cmd    = '{sel: cmd_sel, in0: cmd_in0, in1: cmd_in1};
    assign head      = mem_q[rd_ptr_q];

`ifdef ALU_ISSUE_DZ_CHECK_EN
    assign head_dz = ((head.sel == 3'd3) || (head.sel == 3'd7)) && (head.in1 == '0);
`else
    assign head_dz = 1'b0;
`endif

    // Write the accepted command into the FIFO slot at the write pointer.
    // NOTE: the storage array has no reset; count and pointers alone say which slots hold live data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_cmd;
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Next state, pop decision, ALU drive and result capture.
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_sel_d   = alu_sel_q;
        alu_in0_d   = alu_in0_q;
        alu_in1_d   = alu_in1_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_sel_d   = res_sel_q;
        res_dz_d    = res_dz_q;
        pop         = 1'b0;

        unique case (state_q)
            IDLE: begin
                pop = !empty;
            end
            DRIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_data_d  = alu_out;
                    res_sel_d   = alu_sel_q;
                    res_dz_d    = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (empty) begin
                        state_d = IDLE;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Launching the head command is identical from IDLE and from HOLD.
        if (pop) begin
            if (head_dz) begin
                res_data_d  = '0;
                res_sel_d   = head.sel;
                res_dz_d    = 1'b1;
                res_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = HOLD;
            end else begin
                alu_sel_d = head.sel;
                alu_in0_d = head.in0;
                alu_in1_d = head.in1;
                cnt_d     = CNT_W'(SETTLE_CYCLES);
                state_d   = DRIVE;
            end
        end
    end

    // State, pointer and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_sel_q   <= '0;
            alu_in0_q   <= '0;
            alu_in1_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
            res_dz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            alu_sel_q   <= alu_sel_d;
            alu_in0_q   <= alu_in0_d;
            alu_in1_q   <= alu_in1_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sel_q   <= res_sel_d;
            res_dz_q    <= res_dz_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign alu_sel    = alu_sel_q;
    assign alu_in0    = alu_in0_q;
    assign alu_in1    = alu_in1_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_sel    = res_sel_q;
    assign res_dz     = res_dz_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed steps from the test plan, then a
// randomized phase scored against a queue-based reference model. A second
// instance runs with SETTLE_CYCLES=3.
module tb_alu_issue_ctrl;

    localparam int DW = 3;
    localparam int RW = 2 * DW + 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Default-parameter instance signals
    logic                 cmd_valid, cmd_ready;
    logic [2:0]           cmd_sel;
    logic [DW-1:0]        cmd_in0, cmd_in1;
    logic [2:0]           alu_sel;
    logic [DW-1:0]        alu_in0, alu_in1;
    logic signed [RW-1:0] alu_out;
    logic                 res_valid, res_ready, res_dz;
    logic signed [RW-1:0] res_data;
    logic [2:0]           res_sel;
    logic [2:0]           fifo_count;

    // SETTLE_CYCLES=3 instance signals
    logic                 cmd_valid3, cmd_ready3;
    logic [2:0]           cmd_sel3;
    logic [DW-1:0]        cmd_in0_3, cmd_in1_3;
    logic [2:0]           alu_sel3;
    logic [DW-1:0]        alu_in0_3, alu_in1_3;
    logic signed [RW-1:0] alu_out3;
    logic                 res_valid3, res_ready3, res_dz3;
    logic signed [RW-1:0] res_data3;
    logic [2:0]           res_sel3;
    logic [2:0]           fifo_count3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]           sel;
        logic signed [RW-1:0] data;
        logic                 dz;
    } res_t;

    res_t exp_q[$];

    // Arithmetic result of the ALU; division/modulo by zero yields -1.
    function automatic logic signed [RW-1:0] alu_ref(input logic [2:0] s,
                                                     input logic [DW-1:0] a,
                                                     input logic [DW-1:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (s)
            3'd0:    r = ia + ib;
            3'd1:    r = ia - ib;
            3'd2:    r = ia * ib;
            3'd3:    r = (ib == 0) ? -1 : ia / ib;
            3'd4:    r = ia & ib;
            3'd5:    r = ia | ib;
            3'd6:    r = ia ^ ib;
            default: r = (ib == 0) ? -1 : ia % ib;
        endcase
        return r[RW-1:0];
    endfunction

    function automatic bit is_dz(input logic [2:0] s, input logic [DW-1:0] b);
`ifdef ALU_ISSUE_DZ_CHECK_EN
        return ((s == 3'd3) || (s == 3'd7)) && (b == '0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic res_t expect_res(input logic [2:0] s,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
        res_t r;
        r.sel  = s;
        r.dz   = is_dz(s, b);
        r.data = r.dz ? '0 : alu_ref(s, a, b);
        return r;
    endfunction

    // Combinational ALUs downstream of each instance
    assign alu_out  = alu_ref(alu_sel, alu_in0, alu_in1);
    assign alu_out3 = alu_ref(alu_sel3, alu_in0_3, alu_in1_3);

    alu_issue_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_in0(cmd_in0), .cmd_in1(cmd_in1),
        .alu_sel(alu_sel), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_sel(res_sel), .res_dz(res_dz),
        .fifo_count(fifo_count)
    );

    alu_issue_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_sel(cmd_sel3), .cmd_in0(cmd_in0_3), .cmd_in1(cmd_in1_3),
        .alu_sel(alu_sel3), .alu_in0(alu_in0_3), .alu_in1(alu_in1_3),
        .alu_out(alu_out3),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_data(res_data3), .res_sel(res_sel3), .res_dz(res_dz3),
        .fifo_count(fifo_count3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_in0   = a;
        cmd_in1   = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(res_valid), 32'd1);
    endtask

    // Consume the held result and return to a quiet state.
    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // Score one cycle of the random phase against the reference queue.
    task automatic score_cycle();
        res_t e;
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back(expect_res(cmd_sel, cmd_in0, cmd_in1));
        end
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("rnd_unexpected_result", 32'(res_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rnd_data", res_data, e.data);
                check("rnd_sel", 32'(res_sel), 32'(e.sel));
                check("rnd_dz", 32'(res_dz), 32'(e.dz));
            end
        end
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int last;
        int t0;
        int n;
        logic signed [RW-1:0] e_data;

        rst        = 1'b1;
        cmd_valid  = 1'b0; cmd_sel   = '0; cmd_in0   = '0; cmd_in1   = '0;
        res_ready  = 1'b0;
        cmd_valid3 = 1'b0; cmd_sel3  = '0; cmd_in0_3 = '0; cmd_in1_3 = '0;
        res_ready3 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_sel", 32'(res_sel), 32'd0);
        check("rst_res_dz", 32'(res_dz), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_alu_in0", 32'(alu_in0), 32'd0);
        check("rst_alu_in1", 32'(alu_in1), 32'd0);
        check("rst_res_valid3", 32'(res_valid3), 32'd0);

        // Add: accepted at E0, driven after E1, result after E2
        send(3'd0, 3'd3, 3'd5);
        check("add_count_e0", 32'(fifo_count), 32'd1);
        check("add_valid_e0", 32'(res_valid), 32'd0);
        tick();
        check("add_alu_sel", 32'(alu_sel), 32'd0);
        check("add_alu_in0", 32'(alu_in0), 32'd3);
        check("add_alu_in1", 32'(alu_in1), 32'd5);
        check("add_count_e1", 32'(fifo_count), 32'd0);
        check("add_valid_e1", 32'(res_valid), 32'd0);
        tick();
        check("add_valid_e2", 32'(res_valid), 32'd1);
        check("add_data", res_data, 32'd8);
        check("add_sel", 32'(res_sel), 32'd0);
        tick();
        check("add_hold_valid", 32'(res_valid), 32'd1);
        check("add_hold_data", res_data, 32'd8);
        consume();
        check("add_released", 32'(res_valid), 32'd0);

        // Sub: negative result keeps all 7 bits
        send(3'd1, 3'd2, 3'd5);
        tick();
        tick();
        check("sub_valid", 32'(res_valid), 32'd1);
        check("sub_data", res_data, 32'hFFFF_FFFD);
        check("sub_sel", 32'(res_sel), 32'd1);
        check("sub_dz", 32'(res_dz), 32'd0);
        consume();

        // Backpressure: 7 offers, 5 accepted (4 queued + 1 held)
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            cmd_valid = 1'b1;
            cmd_sel   = 3'd2;
            cmd_in0   = i[DW-1:0];
            cmd_in1   = 3'd3;
            if (cmd_ready) acc++;
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_fifo_count", 32'(fifo_count), 32'd4);
        res_ready = 1'b1;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_res("bp_wait");
            check("bp_data", res_data, 32'(3 * k));
            if (k > 0) check("bp_gap", 32'(cyc - last), 32'd2);
            last = cyc;
            tick();
            if (k == 0) check("bp_ready_rise", 32'(cmd_ready), 32'd1);
        end
        res_ready = 1'b0;
        tick();
        check("bp_drained_valid", 32'(res_valid), 32'd0);
        check("bp_drained_count", 32'(fifo_count), 32'd0);

        // Divide by zero (last driven command was {2,4,3})
        send(3'd3, 3'd6, 3'd0);
        tick();
`ifdef ALU_ISSUE_DZ_CHECK_EN
        check("dz_valid", 32'(res_valid), 32'd1);
        check("dz_data", res_data, 32'd0);
        check("dz_flag", 32'(res_dz), 32'd1);
        check("dz_sel", 32'(res_sel), 32'd3);
        check("dz_alu_sel_kept", 32'(alu_sel), 32'd2);
        check("dz_alu_in0_kept", 32'(alu_in0), 32'd4);
        check("dz_alu_in1_kept", 32'(alu_in1), 32'd3);
`else
        check("dz_alu_sel", 32'(alu_sel), 32'd3);
        check("dz_alu_in0", 32'(alu_in0), 32'd6);
        check("dz_alu_in1", 32'(alu_in1), 32'd0);
        tick();
        e_data = alu_ref(3'd3, 3'd6, 3'd0);
        check("dz_valid", 32'(res_valid), 32'd1);
        check("dz_data", res_data, e_data);
        check("dz_flag", 32'(res_dz), 32'd0);
        check("dz_sel", 32'(res_sel), 32'd3);
`endif
        consume();

        // Reset while the second of three queued commands is in DRIVE
        send(3'd0, 3'd1, 3'd1);
        send(3'd4, 3'd7, 3'd5);
        send(3'd5, 3'd2, 3'd4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("mid_alu_sel_drive", 32'(alu_sel), 32'd4);
        check("mid_count_before", 32'(fifo_count), 32'd1);
        check("mid_valid_before", 32'(res_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_fifo_count", 32'(fifo_count), 32'd0);
        check("mid_res_valid", 32'(res_valid), 32'd0);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_alu_sel", 32'(alu_sel), 32'd0);
        check("mid_alu_in0", 32'(alu_in0), 32'd0);
        check("mid_alu_in1", 32'(alu_in1), 32'd0);
        check("mid_res_data", res_data, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mid_no_stale", 32'(res_valid), 32'd0);
        end
        check("mid_count_after", 32'(fifo_count), 32'd0);

        // SETTLE_CYCLES=3: mod 7 % 4, res_valid 4 edges after acceptance
        cmd_valid3 = 1'b1;
        cmd_sel3   = 3'd7;
        cmd_in0_3  = 3'd7;
        cmd_in1_3  = 3'd4;
        tick();
        cmd_valid3 = 1'b0;
        t0 = cyc;
        n  = 0;
        while (!res_valid3 && n < 20) begin
            tick();
            n++;
        end
        check("s3_valid", 32'(res_valid3), 32'd1);
        check("s3_latency", 32'(cyc - t0), 32'd4);
        check("s3_data", res_data3, 32'd3);
        check("s3_sel", 32'(res_sel3), 32'd7);
        res_ready3 = 1'b1;
        tick();
        res_ready3 = 1'b0;
        check("s3_released", 32'(res_valid3), 32'd0);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_sel   = 3'($urandom_range(0, 7));
            cmd_in0   = DW'($urandom_range(0, 7));
            cmd_in1   = DW'($urandom_range(0, 7));
            res_ready = ($urandom_range(0, 2) != 0);
            score_cycle();
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            score_cycle();
            tick();
            n++;
        end
        check("rnd_all_delivered", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        check("rnd_final_valid", 32'(res_valid), 32'd0);
        check("rnd_final_count", 32'(fifo_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front-end that sits directly upstream of the `alu` combinational block. It accepts ALU commands `{sel, in0, in1}` over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the ALU inputs, waits a fixed settle interval, then captures `out` and presents it downstream with its own valid/ready handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 3 — operand width; must match the ALU instance.
- `FIFO_DEPTH`, 4 — command FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, 1 — cycles the ALU inputs are held before capture; ≥1 (0 is illegal).

Ports:
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `cmd_valid` input 1 — command present.
- `cmd_ready` output 1 — FIFO not full.
- `cmd_sel` input 3 — opcode: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 mod.
- `cmd_in0`, `cmd_in1` input DATA_WIDTH — unsigned operands.
- `alu_sel` output 3; `alu_in0`, `alu_in1` output DATA_WIDTH — registered drive to the ALU.
- `alu_out` input 2*DATA_WIDTH+1, signed — ALU result.
- `res_valid` output 1 — result held.
- `res_ready` input 1 — consumer accepts.
- `res_data` output 2*DATA_WIDTH+1, signed — captured result.
- `res_sel` output 3 — opcode of the result.
- `res_dz` output 1 — divide/modulo by zero flag.
- `fifo_count` output clog2(FIFO_DEPTH)+1 — queued entries.

## Operation
- Push when `cmd_valid && cmd_ready`. `cmd_ready = (fifo_count != FIFO_DEPTH)`.
  - Push is blocked when full, even if a pop occurs in the same cycle.
  - No empty-FIFO bypass.
- Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states IDLE, DRIVE, HOLD:
  - **IDLE**: if the FIFO is non-empty, pop, load `alu_*` from the head entry, load `cnt=SETTLE_CYCLES`, and go to DRIVE. Otherwise stay.
  - **DRIVE**: `cnt` decrements each cycle. On the cycle where `cnt==1`, latch `res_data<=alu_out`, `res_sel<=alu_sel`, `res_dz<=0`, `res_valid<=1`, and go to HOLD.
  - **HOLD**: `res_*` are stable while `res_valid && !res_ready`. When `res_ready`:
    - `res_valid<=0`.
    - If the FIFO is non-empty, pop and go directly to DRIVE (same load as IDLE).
    - Otherwise go to IDLE.
- `alu_*` keep their last driven values in IDLE and HOLD.
- `res_data` is the `alu_out` bits unchanged. There is no sign extension or truncation; width is 2*DATA_WIDTH+1.
- Reset, including mid-operation, performs all of the following:
  - Flushes the FIFO.
  - Discards any in-flight or held result.
  - Returns the FSM to IDLE.
  - Clears `cnt`.
- Reset values: `cmd_ready=1`, `alu_sel=0`, `alu_in0=0`, `alu_in1=0`, `res_valid=0`, `res_data=0`, `res_sel=0`, `res_dz=0`, `fifo_count=0`.

## Timing
- Command accepted at edge E0:
  - Popped at E1 (FIFO was empty and the FSM was in IDLE).
  - `alu_*` valid after E1.
  - Result captured at E1+SETTLE_CYCLES.
  - `res_valid` high from E1+SETTLE_CYCLES.
- Default latency (S=1): 2 cycles from acceptance to `res_valid`.
- Throughput with `res_ready=1` tied high: one result per SETTLE_CYCLES+1 cycles.
- Capacity with `res_ready=0`: FIFO_DEPTH queued plus one held, i.e. 5 accepted commands at defaults.
- `cmd_ready` drops the cycle after the count reaches FIFO_DEPTH. It rises the cycle after a pop.

## Configuration
- `ALU_ISSUE_DZ_CHECK_EN` defined:
  - A popped command with `sel` of 3 or 7 and `in1==0` is not driven to the ALU; `alu_*` retain their previous values.
  - The FSM goes straight to HOLD with `res_data=0`, `res_sel=sel`, `res_dz=1`.
  - `res_valid` rises one cycle after the pop edge.
- Undefined:
  - `res_dz` is tied to 0.
  - Every command goes through DRIVE, and `res_data` is whatever `alu_out` presents.

## Test plan
- **Add**, defaults: push sel=0, in0=3, in1=5 at E0 → `alu_*` = {0,3,5} after E1; `res_valid=1`, `res_data=8`, `res_sel=0` after E2.
- **Sub**: sel=1, in0=2, in1=5 → `res_data=-3` (7'b1111101), `res_dz=0`.
- **Backpressure**: `res_ready=0`, stream 7 commands {sel=2, in0=i, in1=3} with i=0..6.
  - Exactly 5 are accepted, then `cmd_ready=0` and `fifo_count=4`.
  - Release `res_ready`: results 0, 3, 6, 9, 12 arrive in order, one per 2 cycles.
- **Divide by zero**: sel=3, in0=6, in1=0.
  - With `ALU_ISSUE_DZ_CHECK_EN`: `res_valid` one cycle after the pop, `res_data=0`, `res_dz=1`, `alu_*` unchanged.
  - Without: `res_data` equals the sampled `alu_out`, `res_dz=0`.
- **Reset mid-operation**: queue 3 commands, assert `rst` for 1 cycle while in DRIVE.
  - Next cycle: `fifo_count=0`, `res_valid=0`, `cmd_ready=1`, all `alu_*` = 0.
  - No stale result ever appears.
- **SETTLE_CYCLES=3**: mod sel=7, in0=7, in1=4 → `res_valid` 4 cycles after acceptance, `res_data=3`.
